// File: rtl/game_countdown_pkg.sv
// game_countdown_pkg: shared FSM state type, value width and low-time threshold for game_countdown
package game_countdown_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXPIRED} state_t;
  localparam int VAL_W = 7;
  localparam logic [VAL_W-1:0] LOW_THRESH = 7'd10;
endpackage

// File: rtl/bin2bcd_2digit.sv
// bin2bcd_2digit: combinational 7-bit binary (0..99) to tens/ones BCD; i_bin in, o_tens/o_ones out
module bin2bcd_2digit (
  input  logic [6:0] i_bin,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);
  logic [6:0] w_tens, w_ones;
  assign w_tens = i_bin / 7'd10;
  assign w_ones = i_bin % 7'd10;
  assign o_tens = w_tens[3:0];
  assign o_ones = w_ones[3:0];
endmodule

// File: rtl/game_countdown.sv
// game_countdown: BCD seconds countdown with load/bonus/tick and expiry flag; optional blink warning on lowTime when GAME_COUNTDOWN_LOWTIME_EN is defined
module game_countdown
  import game_countdown_pkg::*;
#(
  parameter int LOAD_VALUE = 60,
  parameter int ADD_VALUE  = 30,
  parameter int MAX_VALUE  = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       OneSecPulse,
  input  logic       countLoadN,
  input  logic       countEnable,
  input  logic       add_thirtySecN,
  output logic       timerEnd,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       lowTime
);
  localparam logic [VAL_W-1:0] LOAD_W = VAL_W'(LOAD_VALUE);
  localparam logic [VAL_W:0]   ADD_W  = (VAL_W+1)'(ADD_VALUE);
  localparam logic [VAL_W:0]   MAX_W  = (VAL_W+1)'(MAX_VALUE);
  state_t r_state, w_state;
  logic [VAL_W-1:0] r_value, w_value, w_sat, w_base, w_dec;
  logic [VAL_W:0] w_sum;
  logic r_end, w_end, r_bonus_prev, w_bonus;
  assign w_bonus = r_bonus_prev & ~add_thirtySecN;
  assign w_sum   = {1'b0, r_value} + ADD_W;
  assign w_sat   = w_sum > MAX_W ? MAX_W[VAL_W-1:0] : w_sum[VAL_W-1:0];
  assign w_base  = w_bonus ? w_sat : r_value;
  assign w_dec   = (OneSecPulse && w_base != '0) ? w_base - 1'b1 : w_base;
  always_comb begin
    w_state = r_state;
    w_value = r_value;
    w_end   = r_end;
    if (!countLoadN) begin
      w_value = LOAD_W;
      w_state = LOAD_W == '0 ? S_EXPIRED : S_RUN;
      w_end   = LOAD_W == '0;
    end else if (r_state == S_RUN && countEnable) begin
      w_value = w_dec;
      w_state = w_dec == '0 ? S_EXPIRED : S_RUN;
      w_end   = w_dec == '0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state      <= S_IDLE;
      r_value      <= '0;
      r_end        <= 1'b0;
      r_bonus_prev <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_value      <= w_value;
      r_end        <= w_end;
      r_bonus_prev <= add_thirtySecN;
    end
  assign timerEnd = r_end;
  bin2bcd_2digit u_bcd (.i_bin(r_value), .o_tens(tens), .o_ones(ones));
`ifdef GAME_COUNTDOWN_LOWTIME_EN
  logic r_blink, w_win;
  assign w_win = r_state == S_RUN && r_value <= LOW_THRESH && r_value != '0;
  // Phase is held at 1 outside the window so the first in-window cycle shows high.
  always_ff @(posedge clk or posedge reset)
    if (reset) r_blink <= 1'b1;
    else r_blink <= (!w_win || !countLoadN) ? 1'b1 : r_blink ^ OneSecPulse;
  assign lowTime = w_win & r_blink;
`else
  assign lowTime = 1'b0;
`endif
endmodule

// File: tb/tb_game_countdown.sv
// tb_game_countdown: directed self-checking bench for game_countdown
module tb_game_countdown;
  import game_countdown_pkg::*;
  logic clk = 1'b0, reset = 1'b1, OneSecPulse = 1'b0, countLoadN = 1'b1, countEnable = 1'b0, add_thirtySecN = 1'b1;
  logic timerEnd, lowTime;
  logic [3:0] tens, ones;
  int total = 0, bad = 0;
  game_countdown dut (
    .clk(clk), .reset(reset), .OneSecPulse(OneSecPulse), .countLoadN(countLoadN),
    .countEnable(countEnable), .add_thirtySecN(add_thirtySecN),
    .timerEnd(timerEnd), .tens(tens), .ones(ones), .lowTime(lowTime)
  );
  always #5 clk = ~clk;
  function automatic int val();
    return int'(tens) * 10 + int'(ones);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      OneSecPulse = 1'b1;
      step();
      OneSecPulse = 1'b0;
      step();
    end
  endtask
  task automatic bonus();
    add_thirtySecN = 1'b0;
    step();
    add_thirtySecN = 1'b1;
    step();
  endtask
  task automatic load();
    countLoadN = 1'b0;
    step();
    countLoadN = 1'b1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    step();
    total++; if (tens !== 4'd0) begin bad++; $display("FAIL reset_tens got=%0d exp=0", tens); end
    total++; if (ones !== 4'd0) begin bad++; $display("FAIL reset_ones got=%0d exp=0", ones); end
    total++; if (timerEnd !== 1'b0) begin bad++; $display("FAIL reset_end got=%b exp=0", timerEnd); end
    total++; if (lowTime !== 1'b0) begin bad++; $display("FAIL reset_low got=%b exp=0", lowTime); end
    @(negedge clk);
    reset = 1'b0;
    countEnable = 1'b1;
    pulse(3);
    bonus();
    total++; if (val() !== 0) begin bad++; $display("FAIL idle_hold got=%0d exp=0", val()); end
    total++; if (timerEnd !== 1'b0) begin bad++; $display("FAIL idle_end got=%b exp=0", timerEnd); end
  endtask
  task automatic test_load_countdown();
    load();
    total++; if (tens !== 4'd6 || ones !== 4'd0) begin bad++; $display("FAIL load_bcd got=%0d%0d exp=60", tens, ones); end
    total++; if (dut.r_state !== S_RUN) begin bad++; $display("FAIL load_state got=%0d exp=%0d", dut.r_state, S_RUN); end
    pulse(59);
    total++; if (val() !== 1 || timerEnd !== 1'b0) begin bad++; $display("FAIL count_59 got=%0d/%b exp=1/0", val(), timerEnd); end
    OneSecPulse = 1'b1;
    step();
    OneSecPulse = 1'b0;
    total++; if (val() !== 0 || timerEnd !== 1'b1) begin bad++; $display("FAIL expire_edge got=%0d/%b exp=0/1", val(), timerEnd); end
    pulse(3);
    bonus();
    total++; if (val() !== 0 || timerEnd !== 1'b1) begin bad++; $display("FAIL expired_hold got=%0d/%b exp=0/1", val(), timerEnd); end
  endtask
  task automatic test_bonus_saturate();
    load();
    bonus();
    total++; if (val() !== 90) begin bad++; $display("FAIL bonus_add got=%0d exp=90", val()); end
    pulse(15);
    add_thirtySecN = 1'b0;
    repeat (20) step();
    total++; if (val() !== 99) begin bad++; $display("FAIL bonus_sat got=%0d exp=99", val()); end
    pulse(1);
    add_thirtySecN = 1'b1;
    step();
    total++; if (val() !== 98) begin bad++; $display("FAIL bonus_once_sat got=%0d exp=98", val()); end
    pulse(78);
    add_thirtySecN = 1'b0;
    repeat (20) step();
    add_thirtySecN = 1'b1;
    step();
    total++; if (val() !== 50) begin bad++; $display("FAIL bonus_once got=%0d exp=50", val()); end
  endtask
  task automatic test_bonus_tick();
    pulse(10);
    add_thirtySecN = 1'b0;
    OneSecPulse = 1'b1;
    step();
    add_thirtySecN = 1'b1;
    OneSecPulse = 1'b0;
    total++; if (val() !== 69) begin bad++; $display("FAIL bonus_tick got=%0d exp=69", val()); end
    step();
  endtask
  task automatic test_enable_hold();
    pulse(68);
    countEnable = 1'b0;
    pulse(5);
    bonus();
    total++; if (val() !== 1 || timerEnd !== 1'b0) begin bad++; $display("FAIL disable_hold got=%0d/%b exp=1/0", val(), timerEnd); end
    countEnable = 1'b1;
    OneSecPulse = 1'b1;
    step();
    OneSecPulse = 1'b0;
    total++; if (val() !== 0 || timerEnd !== 1'b1) begin bad++; $display("FAIL enable_expire got=%0d/%b exp=0/1", val(), timerEnd); end
    load();
    total++; if (val() !== 60 || timerEnd !== 1'b0) begin bad++; $display("FAIL reload got=%0d/%b exp=60/0", val(), timerEnd); end
  endtask
  task automatic test_async_reset();
    pulse(27);
    total++; if (val() !== 33) begin bad++; $display("FAIL pre_reset got=%0d exp=33", val()); end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    total++; if (val() !== 0 || timerEnd !== 1'b0) begin bad++; $display("FAIL async_reset got=%0d/%b exp=0/0", val(), timerEnd); end
    @(negedge clk);
    reset = 1'b0;
    countLoadN = 1'b0;
    add_thirtySecN = 1'b0;
    OneSecPulse = 1'b1;
    step();
    countLoadN = 1'b1;
    total++; if (val() !== 60) begin bad++; $display("FAIL load_priority got=%0d exp=60", val()); end
    step();
    OneSecPulse = 1'b0;
    add_thirtySecN = 1'b1;
    total++; if (val() !== 59) begin bad++; $display("FAIL held_after_load got=%0d exp=59", val()); end
    step();
  endtask
  task automatic test_lowtime();
`ifdef GAME_COUNTDOWN_LOWTIME_EN
    pulse(48);
    total++; if (val() !== 11 || lowTime !== 1'b0) begin bad++; $display("FAIL low_11 got=%0d/%b exp=11/0", val(), lowTime); end
    OneSecPulse = 1'b1;
    step();
    OneSecPulse = 1'b0;
    total++; if (lowTime !== 1'b1) begin bad++; $display("FAIL low_10 got=%b exp=1", lowTime); end
    step();
    OneSecPulse = 1'b1;
    step();
    OneSecPulse = 1'b0;
    total++; if (val() !== 9 || lowTime !== 1'b0) begin bad++; $display("FAIL low_9 got=%0d/%b exp=9/0", val(), lowTime); end
    pulse(9);
    total++; if (val() !== 0 || lowTime !== 1'b0 || timerEnd !== 1'b1) begin bad++; $display("FAIL low_0 got=%0d/%b/%b exp=0/0/1", val(), lowTime, timerEnd); end
`else
    pulse(49);
    total++; if (val() !== 10 || lowTime !== 1'b0) begin bad++; $display("FAIL low_off_10 got=%0d/%b exp=10/0", val(), lowTime); end
    pulse(10);
    total++; if (val() !== 0 || lowTime !== 1'b0 || timerEnd !== 1'b1) begin bad++; $display("FAIL low_off_0 got=%0d/%b/%b exp=0/0/1", val(), lowTime, timerEnd); end
`endif
  endtask
  initial begin
    test_reset();
    test_load_countdown();
    test_bonus_saturate();
    test_bonus_tick();
    test_enable_hold();
    test_async_reset();
    test_lowtime();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
